// File: rtl/el_dr_sync_sink.sv
// Dual-rail completion sink: syncs adder rails into clk and runs the 4-phase ack.
// Ports: in_s/in_c rails in, ack_o out, out_sum/out_carry/out_valid/out_ready register, err (EL_DR_SINK_ERR_EN).
module el_dr_sync_sink #(
  parameter int WIDTH       = 32,
  parameter int RAIL_NUM    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RAIL_NUM*WIDTH-1:0] in_s,
  input  logic [RAIL_NUM-1:0]       in_c,
  output logic                      ack_o,
  output logic [WIDTH-1:0]          out_sum,
  output logic                      out_carry,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      err
);

  localparam int NP = WIDTH + 1;
  localparam int NR = RAIL_NUM * NP;

  localparam logic [0:0] WAIT_DATA = 1'b0;
  localparam logic [0:0] WAIT_NULL = 1'b1;

  if (RAIL_NUM != 2) begin : g_bad_rails
    $error("el_dr_sync_sink: RAIL_NUM must be 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("el_dr_sync_sink: SYNC_STAGES must be >= 2");
  end

  logic [NR-1:0] sync_q [SYNC_STAGES];
  logic [NR-1:0] rails;
  logic [NP-1:0] dec;
  logic          all_data;
  logic          all_null;
  logic          illegal;
  logic [0:0]    state_q;
  logic          load;
  logic          drop;

  // Carry pair sits above the sum pairs so pair WIDTH is the carry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= {in_c, in_s};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rails = sync_q[SYNC_STAGES-1];

  always_comb begin
    all_data = 1'b1;
    all_null = 1'b1;
    illegal  = 1'b0;
    dec      = '0;
    for (int p = 0; p < NP; p++) begin
      unique case (rails[2*p +: 2])
        2'b00: all_data = 1'b0;
        2'b01: all_null = 1'b0;
        2'b10: all_null = 1'b0;
        default: begin
          all_data = 1'b0;
          all_null = 1'b0;
          illegal  = 1'b1;
        end
      endcase
      dec[p] = rails[2*p+1];
    end
  end

  // A full register that is not draining blocks capture, which
  // keeps ack low and stalls the producer in its DATA phase.
  always_comb begin
    load = 1'b0;
    drop = 1'b0;
    unique case (1'b1)
      (state_q == WAIT_DATA):
        load = all_data & (~out_valid | out_ready);
      (state_q == WAIT_NULL):
        drop = all_null;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_DATA;
    end else if (load) begin
      state_q <= WAIT_NULL;
    end else if (drop) begin
      state_q <= WAIT_DATA;
    end
  end

  assign ack_o = (state_q == WAIT_NULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_sum   <= dec[WIDTH-1:0];
      out_carry <= dec[WIDTH];
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef EL_DR_SINK_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (illegal) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  // Without detection an illegal pair only blocks capture.
  logic unused_illegal;
  assign unused_illegal = illegal;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_el_dr_sync_sink.sv
// Bench for el_dr_sync_sink: directed phases plus random 4-phase tokens.
// A queue-delay model of the sink is checked on every clock edge.
module tb_el_dr_sync_sink;

  localparam int W  = 32;
  localparam int S  = 2;
  localparam int NR = 2 * (W + 1);
`ifdef EL_DR_SINK_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2*W-1:0] in_s = '0;
  logic [1:0]    in_c = '0;
  logic          ack_o;
  logic [W-1:0]  out_sum;
  logic          out_carry;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          err;

  int n_chk  = 0;
  int n_fail = 0;
  bit rnd_ready = 1'b0;

  el_dr_sync_sink #(.WIDTH(W), .RAIL_NUM(2), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_s(in_s), .in_c(in_c),
    .ack_o(ack_o), .out_sum(out_sum), .out_carry(out_carry),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [NR-1:0] enc(input logic [W-1:0] s,
                                         input logic c);
    logic [W:0] b;
    logic [NR-1:0] v;
    b = {c, s};
    v = '0;
    for (int i = 0; i <= W; i++) v[2*i +: 2] = b[i] ? 2'b10 : 2'b01;
    return v;
  endfunction

  task automatic drive(input logic [NR-1:0] v);
    {in_c, in_s} = v;
  endtask

  // ---------------- reference model ----------------
  // Synced view = input word seen S edges earlier (zeros after reset).
  logic [NR-1:0] hist[$];
  bit            m_wait = 1'b1;
  logic          m_valid = 1'b0;
  logic [W-1:0]  m_sum = '0;
  logic          m_carry = 1'b0;
  logic          m_err = 1'b0;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S; i++) hist.push_back('0);
    m_wait = 1'b1; m_valid = 1'b0; m_sum = '0;
    m_carry = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    logic [NR-1:0] w;
    int nd, nn, ni;
    logic [W:0] bits;
    bit ld, was_wait;
    w = hist[0];
    void'(hist.pop_front());
    hist.push_back({in_c, in_s});
    nd = 0; nn = 0; ni = 0; bits = '0;
    for (int p = 0; p <= W; p++) begin
      logic [1:0] pr;
      pr = w[2*p +: 2];
      if (pr == 2'b00) nn++;
      else if (pr == 2'b11) ni++;
      else nd++;
      bits[p] = (pr == 2'b10);
    end
    was_wait = m_wait;
    ld = was_wait && nd == W + 1 && (!m_valid || out_ready);
    if (ld) begin
      m_sum = bits[W-1:0]; m_carry = bits[W];
      m_valid = 1'b1; m_wait = 1'b0;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (!was_wait && nn == W + 1) m_wait = 1'b1;
    if (ERR_EN && ni > 0) m_err = 1'b1;
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else begin
      model_step();
      #1;
      chk("m_ack", ack_o, !m_wait);
      chk("m_valid", out_valid, m_valid);
      chk("m_sum", out_sum, m_sum);
      chk("m_carry", out_carry, m_carry);
      chk("m_err", err, m_err);
    end
  end

  always @(negedge clk) begin
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- helpers ----------------
  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input logic val, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      edge1();
      if (ack_o === val) ok = 1'b1;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_ack got=%b want=%b t=%0t", ack_o, val, $time);
    end
  endtask

  task automatic send_token(input logic [W-1:0] s, input logic c);
    logic [NR-1:0] v, cur;
    v = enc(s, c);
    cur = '0;
    for (int k = 0; k < $urandom_range(0, 3); k++) begin
      @(negedge clk);
      cur |= v & {$urandom, $urandom, $urandom};
      drive(cur);
    end
    @(negedge clk);
    drive(v);
    wait_ack(1'b1, 400);
    for (int k = 0; k < $urandom_range(0, 3); k++) begin
      @(negedge clk);
      cur = v & {$urandom, $urandom, $urandom};
      v = cur;
      drive(cur);
    end
    @(negedge clk);
    drive('0);
    wait_ack(1'b0, 400);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NR-1:0] v;

    // 1: reset holds outputs at zero regardless of rails
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive({$urandom, $urandom, $urandom});
    end
    edge1();
    chk("rst_ack", ack_o, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_carry", out_carry, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    drive('0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) edge1();
    chk("idle_ack", ack_o, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_sum", out_sum, 0);

    // 2: capture latency is S+1 edges both ways
    out_ready = 1'b1;
    @(negedge clk);
    drive(enc(32'h0000_00A5, 1'b1));
    edge1();
    edge1();
    chk("t2_ack_e2", ack_o, 0);
    edge1();
    chk("t2_ack_e3", ack_o, 1);
    chk("t2_valid", out_valid, 1);
    chk("t2_sum", out_sum, 32'hA5);
    chk("t2_carry", out_carry, 1);
    @(negedge clk);
    drive('0);
    edge1();
    edge1();
    chk("t2_null_e2", ack_o, 1);
    edge1();
    chk("t2_null_e3", ack_o, 0);

    // 3: backpressure holds the register and the ack
    @(negedge clk);
    out_ready = 1'b0;
    drive(enc(32'h1, 1'b0));
    wait_ack(1'b1, 10);
    chk("t3_sum1", out_sum, 32'h1);
    @(negedge clk);
    drive('0);
    wait_ack(1'b0, 10);
    @(negedge clk);
    drive(enc(32'h2, 1'b0));
    for (int i = 0; i < 6; i++) edge1();
    chk("t3_stall_ack", ack_o, 0);
    chk("t3_held_sum", out_sum, 32'h1);
    chk("t3_held_valid", out_valid, 1);
    @(negedge clk);
    out_ready = 1'b1;
    edge1();
    chk("t3_load_sum", out_sum, 32'h2);
    chk("t3_load_valid", out_valid, 1);
    chk("t3_load_ack", ack_o, 1);
    @(negedge clk);
    out_ready = 1'b0;
    drive('0);
    wait_ack(1'b0, 10);
    @(negedge clk);
    out_ready = 1'b1;
    edge1();

    // 4: a mixed word is never captured
    v = enc(32'h8000_1234, 1'b0);
    @(negedge clk);
    drive({v[NR-1:NR-2], 2'b00, v[NR-5:0]});
    for (int i = 0; i < 5; i++) begin
      edge1();
      chk("t4_partial_ack", ack_o, 0);
    end
    @(negedge clk);
    drive(v);
    edge1();
    edge1();
    chk("t4_e2", ack_o, 0);
    edge1();
    chk("t4_e3", ack_o, 1);
    chk("t4_sum", out_sum, 32'h8000_1234);
    @(negedge clk);
    drive('0);
    wait_ack(1'b0, 10);
    edge1();

    // 5: illegal pair blocks capture; err only with detection built in
    v = enc(32'h55, 1'b0);
    v[7:6] = 2'b11;
    @(negedge clk);
    drive(v);
    for (int i = 0; i < 5; i++) edge1();
    chk("t5_ack", ack_o, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_err", err, ERR_EN);
    @(negedge clk);
    drive('0);
    for (int i = 0; i < 4; i++) edge1();
    chk("t5_err_sticky", err, ERR_EN);

    // 6: async reset in WAIT_NULL, then re-delivery of held data
    @(negedge clk);
    drive(enc(32'hCAFE_0001, 1'b1));
    wait_ack(1'b1, 10);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_ack", ack_o, 0);
    chk("t6_async_valid", out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    edge1();
    edge1();
    chk("t6_e2", ack_o, 0);
    edge1();
    chk("t6_e3", ack_o, 1);
    chk("t6_sum", out_sum, 32'hCAFE_0001);
    chk("t6_err", err, 0);
    @(negedge clk);
    drive('0);
    wait_ack(1'b0, 10);

    // random tokens with random backpressure
    rnd_ready = 1'b1;
    for (int t = 0; t < 150; t++) begin
      send_token($urandom, 1'($urandom_range(0, 1)));
    end
    rnd_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) edge1();
    chk("end_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
